// File: rtl/matrix_mac_accel.sv
// matrix_mac_accel: memory-mapped integer matrix-multiply accelerator.
// Computes C = A x B (or C += A x B in accumulate mode) for runtime
// M x K by K x N operands, producing CORE_COUNT C columns per pass.
//
// Ports:
//   CLOCK_25    clock
//   rst         asynchronous active-high reset (control state only)
//   data        bus write data
//   address     [12:10] region, [9:5] row, [4:0] column
//   we          bus write enable
//   o_data_rdt  registered read data, one-cycle latency
//   o_done_irq  one-cycle pulse when an operation completes
module matrix_mac_accel #(
  parameter int CORE_COUNT = 4,
  parameter int ROWS_MAX   = 8,
  parameter int INNER_MAX  = 8,
  parameter int COLS_MAX   = 8,
  parameter int DATA_W     = 32
) (
  input  logic              CLOCK_25,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [12:0]       address,
  input  logic              we,
  output logic [DATA_W-1:0] o_data_rdt,
  output logic              o_done_irq
);

  localparam int RW = (ROWS_MAX  > 1) ? $clog2(ROWS_MAX)  : 1;
  localparam int KW = (INNER_MAX > 1) ? $clog2(INNER_MAX) : 1;
  localparam int CW = (COLS_MAX  > 1) ? $clog2(COLS_MAX)  : 1;
  localparam logic [5:0] ROW_LIM   = 6'(ROWS_MAX);
  localparam logic [5:0] INNER_LIM = 6'(INNER_MAX);
  localparam logic [5:0] COL_LIM   = 6'(COLS_MAX);

  typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, DONE} state_t;

  // Wrapping multiply-accumulate: only the low DATA_W bits are kept, so
  // the result is the same for signed and unsigned interpretations.
  function automatic logic signed [DATA_W-1:0] mac_wrap(
    input logic signed [DATA_W-1:0] acc_in,
    input logic signed [DATA_W-1:0] a_in,
    input logic signed [DATA_W-1:0] b_in
  );
    logic signed [DATA_W-1:0] prod;
    prod = a_in * b_in;
    return acc_in + prod;
  endfunction

  logic signed [DATA_W-1:0] a_mem [ROWS_MAX][INNER_MAX];
  logic signed [DATA_W-1:0] b_mem [INNER_MAX][COLS_MAX];
  logic signed [DATA_W-1:0] c_mem [ROWS_MAX][COLS_MAX];
  logic signed [DATA_W-1:0] acc   [CORE_COUNT];

  state_t            state;
  logic [7:0]        m_q, k_q, n_q;
  logic              accum_q, busy, done, error;
  logic [DATA_W-1:0] cycles;
  logic [7:0]        r_idx, c0, k_idx;

  logic [2:0] region;
  logic [4:0] row, col;
  logic       a_ok, b_ok, c_ok, fields_ok;
  logic       wr_ctrl, wr_a, wr_b, wr_c, wr_status;
  logic [7:0] lane_col [CORE_COUNT];
  logic       lane_en  [CORE_COUNT];
  logic       last_blk, last_row;
  logic [DATA_W-1:0] rd_val;

  assign region = address[12:10];
  assign row    = address[9:5];
  assign col    = address[4:0];

  assign a_ok = ({1'b0, row} < ROW_LIM)   && ({1'b0, col} < INNER_LIM);
  assign b_ok = ({1'b0, row} < INNER_LIM) && ({1'b0, col} < COL_LIM);
  assign c_ok = ({1'b0, row} < ROW_LIM)   && ({1'b0, col} < COL_LIM);

  // Matrix and control writes are locked out for the whole operation.
  assign wr_ctrl   = we && (region == 3'd0) && !busy;
  assign wr_a      = we && (region == 3'd1) && !busy && a_ok;
  assign wr_b      = we && (region == 3'd2) && !busy && b_ok;
  assign wr_c      = we && (region == 3'd3) && !busy && c_ok;
  assign wr_status = we && (region == 3'd4);

  assign fields_ok = (data[7:0]   != 8'd0) && (data[7:0]   <= 8'(ROWS_MAX))  &&
                     (data[15:8]  != 8'd0) && (data[15:8]  <= 8'(INNER_MAX)) &&
                     (data[23:16] != 8'd0) && (data[23:16] <= 8'(COLS_MAX));

  always_comb begin
    for (int j = 0; j < CORE_COUNT; j++) begin
      lane_col[j] = c0 + 8'(j);
      lane_en[j]  = lane_col[j] < n_q;
    end
  end

  assign last_blk = ({1'b0, c0} + 9'(CORE_COUNT)) >= {1'b0, n_q};
  assign last_row = r_idx == (m_q - 8'd1);

  // Control FSM: sequences INIT / MAC x K / WRITE per pass.
  always_ff @(posedge CLOCK_25 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      accum_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cycles     <= '0;
      r_idx      <= '0;
      c0         <= '0;
      k_idx      <= '0;
      o_done_irq <= 1'b0;
    end else begin
      o_done_irq <= 1'b0;
      // Flag clear comes first so a same-cycle DONE set takes priority.
      if (wr_status) begin
        done  <= 1'b0;
        error <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (wr_ctrl) begin
            m_q     <= data[7:0];
            k_q     <= data[15:8];
            n_q     <= data[23:16];
            accum_q <= data[25];
            if (data[24]) begin
              if (fields_ok) begin
                busy   <= 1'b1;
                done   <= 1'b0;
                r_idx  <= '0;
                c0     <= '0;
                cycles <= '0;
                state  <= INIT;
              end else begin
                error <= 1'b1;
              end
            end
          end
        end
        INIT: begin
          k_idx  <= '0;
          cycles <= cycles + 1'b1;
          state  <= MAC;
        end
        MAC: begin
          k_idx  <= k_idx + 8'd1;
          cycles <= cycles + 1'b1;
          if (k_idx == k_q - 8'd1) state <= WRITE;
        end
        WRITE: begin
          cycles <= cycles + 1'b1;
          if (!last_blk) begin
            c0 <= c0 + 8'(CORE_COUNT);
          end else begin
            c0    <= '0;
            r_idx <= r_idx + 8'd1;
          end
          state <= (last_blk && last_row) ? DONE : INIT;
        end
        DONE: begin
          busy       <= 1'b0;
          done       <= 1'b1;
          o_done_irq <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: storage and lane accumulators carry no reset.
  always_ff @(posedge CLOCK_25) begin
    if (wr_a) a_mem[row[RW-1:0]][col[KW-1:0]] <= data;
    if (wr_b) b_mem[row[KW-1:0]][col[CW-1:0]] <= data;
    if (state == WRITE) begin
      for (int j = 0; j < CORE_COUNT; j++)
        if (lane_en[j]) c_mem[r_idx[RW-1:0]][lane_col[j][CW-1:0]] <= acc[j];
    end else if (wr_c) begin
      c_mem[row[RW-1:0]][col[CW-1:0]] <= data;
    end
    for (int j = 0; j < CORE_COUNT; j++) begin
      if (state == INIT)
        acc[j] <= accum_q ? c_mem[r_idx[RW-1:0]][lane_col[j][CW-1:0]] : '0;
      else if (state == MAC && lane_en[j])
        acc[j] <= mac_wrap(acc[j], a_mem[r_idx[RW-1:0]][k_idx[KW-1:0]],
                           b_mem[k_idx[KW-1:0]][lane_col[j][CW-1:0]]);
    end
  end

  always_comb begin
    rd_val = '0;
    case (region)
      3'd0: rd_val = DATA_W'({accum_q, 1'b0, n_q, k_q, m_q});
      3'd1: if (a_ok) rd_val = a_mem[row[RW-1:0]][col[KW-1:0]];
      3'd2: if (b_ok) rd_val = b_mem[row[KW-1:0]][col[CW-1:0]];
      3'd3: if (c_ok) rd_val = c_mem[row[RW-1:0]][col[CW-1:0]];
      3'd4: rd_val = DATA_W'({error, done, busy});
      3'd5: rd_val = cycles;
      default: rd_val = '0;
    endcase
  end

  // Read stage: one-cycle registered read data.
  always_ff @(posedge CLOCK_25 or posedge rst) begin
    if (rst) o_data_rdt <= '0;
    else     o_data_rdt <= rd_val;
  end

endmodule

// File: tb/tb_matrix_mac_accel.sv
// tb_matrix_mac_accel: directed self-checking bench for matrix_mac_accel.
module tb_matrix_mac_accel;

  logic        CLOCK_25 = 1'b0;
  logic        rst      = 1'b1;
  logic [31:0] data     = '0;
  logic [12:0] address  = '0;
  logic        we       = 1'b0;
  logic [31:0] o_data_rdt;
  logic        o_done_irq;

  int n_cmp   = 0;
  int n_bad   = 0;
  int irq_cnt = 0;

  matrix_mac_accel #(
    .CORE_COUNT(4), .ROWS_MAX(8), .INNER_MAX(8), .COLS_MAX(8), .DATA_W(32)
  ) dut (
    .CLOCK_25  (CLOCK_25),
    .rst       (rst),
    .data      (data),
    .address   (address),
    .we        (we),
    .o_data_rdt(o_data_rdt),
    .o_done_irq(o_done_irq)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  always @(negedge CLOCK_25) if (o_done_irq) irq_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] addr_of(input int rgn, input int r, input int c);
    return {3'(rgn), 5'(r), 5'(c)};
  endfunction

  task automatic bus_wr(input int rgn, input int r, input int c, input logic [31:0] d);
    @(negedge CLOCK_25);
    address = addr_of(rgn, r, c);
    data    = d;
    we      = 1'b1;
    @(posedge CLOCK_25);
    #1 we = 1'b0;
  endtask

  task automatic bus_rd(input int rgn, input int r, input int c, output logic [31:0] d);
    @(negedge CLOCK_25);
    address = addr_of(rgn, r, c);
    we      = 1'b0;
    @(posedge CLOCK_25);
    #1 d = o_data_rdt;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge CLOCK_25);
      #1;
      if (o_done_irq) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, " done_irq"}, 32'(ok), 32'd1);
    repeat (3) @(posedge CLOCK_25);
  endtask

  task automatic load_ident;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        bus_wr(1, i, j, (i == j) ? 32'd1 : 32'd0);
        bus_wr(2, i, j, 32'(10 * i + j));
      end
  endtask

  task automatic check_c_is_b(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        bus_rd(3, i, j, v);
        check_val($sformatf("%s C[%0d][%0d]", tag, i, j), v, 32'(10 * i + j));
      end
  endtask

  initial begin
    logic [31:0] v;
    int base;

    // Reset state
    repeat (3) @(posedge CLOCK_25);
    #1;
    check_val("rst rdt", o_data_rdt, 32'd0);
    check_val("rst irq", 32'(o_done_irq), 32'd0);
    @(negedge CLOCK_25) rst = 1'b0;
    bus_rd(4, 0, 0, v); check_val("rst status", v, 32'd0);
    bus_rd(5, 0, 0, v); check_val("rst cycles", v, 32'd0);
    bus_rd(0, 0, 0, v); check_val("rst ctrl", v, 32'd0);
    bus_rd(6, 0, 0, v); check_val("region6", v, 32'd0);
    bus_wr(1, 8, 0, 32'd123);
    bus_rd(1, 8, 0, v); check_val("A oob read", v, 32'd0);

    // Scenario 1: identity multiply
    load_ident();
    base = irq_cnt;
    bus_wr(0, 0, 0, 32'h0104_0404);
    wait_done("s1");
    check_c_is_b("s1");
    bus_rd(4, 0, 0, v); check_val("s1 status", v, 32'd2);
    bus_rd(5, 0, 0, v); check_val("s1 cycles", v, 32'd24);
    check_val("s1 irq count", 32'(irq_cnt - base), 32'd1);

    // Scenario 5: busy protection
    base = irq_cnt;
    bus_wr(0, 0, 0, 32'h0104_0404);
    bus_rd(4, 0, 0, v); check_val("s5 busy", 32'(v[0]), 32'd1);
    bus_wr(1, 0, 0, 32'd99);
    bus_wr(0, 0, 0, 32'h0101_0101);
    wait_done("s5");
    check_c_is_b("s5");
    bus_rd(1, 0, 0, v); check_val("s5 A00 kept", v, 32'd1);
    bus_rd(0, 0, 0, v); check_val("s5 ctrl kept", v, 32'h0004_0404);
    bus_rd(5, 0, 0, v); check_val("s5 cycles", v, 32'd24);
    check_val("s5 irq count", 32'(irq_cnt - base), 32'd1);

    // Scenario 2: partial lanes, M=2 K=3 N=5
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) bus_wr(3, r, c, 32'h0000_DEAD);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) bus_wr(1, r, k, 32'd1);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 5; j++) bus_wr(2, k, j, 32'(j + 1));
    bus_wr(0, 0, 0, 32'h0105_0302);
    wait_done("s2");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) begin
        bus_rd(3, r, c, v);
        check_val($sformatf("s2 C[%0d][%0d]", r, c), v,
                  (c < 5) ? 32'(3 * (c + 1)) : 32'h0000_DEAD);
      end
    bus_rd(5, 0, 0, v); check_val("s2 cycles", v, 32'd20);

    // Scenario 3: accumulate mode
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        bus_wr(3, r, c, 32'd7);
        bus_wr(1, r, c, (r == c) ? 32'd1 : 32'd0);
        bus_wr(2, r, c, 32'd2);
      end
    bus_wr(0, 0, 0, 32'h0302_0202);
    wait_done("s3a");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        bus_rd(3, r, c, v);
        check_val($sformatf("s3a C[%0d][%0d]", r, c), v, 32'd9);
      end
    bus_rd(0, 0, 0, v); check_val("s3 ctrl", v, 32'h0202_0202);
    bus_wr(0, 0, 0, 32'h0302_0202);
    wait_done("s3b");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        bus_rd(3, r, c, v);
        check_val($sformatf("s3b C[%0d][%0d]", r, c), v, 32'd11);
      end
    bus_rd(5, 0, 0, v); check_val("s3 cycles", v, 32'd8);

    // Scenario 4: error and wrap
    bus_wr(0, 0, 0, 32'h0101_0001);
    repeat (3) @(posedge CLOCK_25);
    bus_rd(4, 0, 0, v);
    check_val("s4 K0 error", 32'(v[2]), 32'd1);
    check_val("s4 K0 not busy", 32'(v[0]), 32'd0);
    bus_rd(5, 0, 0, v); check_val("s4 K0 cycles", v, 32'd8);
    bus_wr(4, 0, 0, 32'd0);
    bus_rd(4, 0, 0, v); check_val("s4 clear", v, 32'd0);
    bus_wr(0, 0, 0, 32'h0101_0901);
    bus_rd(4, 0, 0, v); check_val("s4 K9 status", v, 32'd4);
    bus_wr(4, 0, 0, 32'd0);
    bus_rd(4, 0, 0, v); check_val("s4 clear2", v, 32'd0);
    bus_wr(1, 0, 0, 32'hFFFF_FFFF);
    bus_wr(2, 0, 0, 32'd2);
    bus_wr(0, 0, 0, 32'h0101_0101);
    wait_done("s4 wrap");
    bus_rd(3, 0, 0, v); check_val("s4 wrap C00", v, 32'hFFFF_FFFE);
    bus_rd(5, 0, 0, v); check_val("s4 wrap cycles", v, 32'd3);

    // Scenario 6: asynchronous reset in the MAC phase of pass 2
    load_ident();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) bus_wr(3, r, c, 32'd0);
    base = irq_cnt;
    bus_wr(0, 0, 0, 32'h0104_0404);
    @(negedge CLOCK_25) address = addr_of(4, 0, 0);
    repeat (8) @(negedge CLOCK_25);
    check_val("s6 busy before rst", o_data_rdt, 32'd1);
    #5 rst = 1'b1;
    #1;
    check_val("s6 rdt on rst", o_data_rdt, 32'd0);
    repeat (2) @(posedge CLOCK_25);
    @(negedge CLOCK_25) rst = 1'b0;
    bus_rd(4, 0, 0, v); check_val("s6 status", v, 32'd0);
    bus_rd(5, 0, 0, v); check_val("s6 cycles", v, 32'd0);
    for (int c = 0; c < 4; c++) begin
      bus_rd(3, 0, c, v); check_val($sformatf("s6 C[0][%0d]", c), v, 32'(c));
      bus_rd(3, 1, c, v); check_val($sformatf("s6 C[1][%0d]", c), v, 32'd0);
    end
    check_val("s6 no irq", 32'(irq_cnt - base), 32'd0);
    bus_wr(0, 0, 0, 32'h0104_0404);
    wait_done("s6 rerun");
    check_c_is_b("s6 rerun");
    bus_rd(5, 0, 0, v); check_val("s6 rerun cycles", v, 32'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_mac_accel.md
Name: matrix_mac_accel

Overview:
Memory-mapped integer matrix-multiply accelerator. It computes C = A x B, or C = C + A x B in accumulate mode, with runtime dimensions M x K times K x N. CORE_COUNT parallel MAC lanes each produce one C element per pass. It sits on the SERV peripheral bus with the same 13-bit word address, write-enable and registered read-data style as the existing matrix accelerator, and adds a status/cycle-count interface.

Parameters:
CORE_COUNT, 4, number of parallel MAC lanes (C columns produced per pass)
ROWS_MAX, 8, max M; A and C row depth (≤32)
INNER_MAX, 8, max K; A column depth and B row depth (≤32)
COLS_MAX, 8, max N; B and C column depth (≤32)
DATA_W, 32, element, accumulator and bus width

Ports:
CLOCK_25  input  1  clock
rst  input  1  asynchronous, active-high reset
data  input  DATA_W  write data
address  input  13  [12:10] region, [9:5] row, [4:0] column
we  input  1  write enable
o_data_rdt  output  DATA_W  registered read data
o_done_irq  output  1  one-cycle pulse when an operation completes

Behaviour:
- Region map, selected by address[12:10]:
  - 0 CTRL: write [7:0] M, [15:8] K, [23:16] N, bit24 start, bit25 accum. Read returns fields; start bit reads 0.
  - 1 A[row][col], read/write.
  - 2 B[row][col], read/write.
  - 3 C[row][col], read/write; writes preload C for accum mode.
  - 4 STATUS: read bit0 busy, bit1 done, bit2 error. Any write clears done and error.
  - 5 CYCLES: read only; cycles used by the last operation.
  - 6 and 7: reads return 0, writes ignored.
- Reads: o_data_rdt updates on every clock edge from the decoded address, so read latency is 1 cycle regardless of we.
- Index bounds: out-of-range row/col writes are ignored; out-of-range reads return 0.
- While busy: writes to CTRL, A, B and C are ignored, and C reads return current contents. STATUS writes still clear flags.
- FSM states: IDLE, INIT, MAC, WRITE, DONE.
  - IDLE: a CTRL write with start=1 latches the fields.
    - If M, K or N is 0, or exceeds ROWS_MAX, INNER_MAX or COLS_MAX: set error and stay IDLE.
    - Otherwise: set busy, clear done, r=0, c0=0, CYCLES=0, go to INIT.
  - INIT (1 cycle): acc_j = accum ? C[r][c0+j] : 0 for each lane j; k=0.
  - MAC (K cycles): acc_j += A[r][k] * B[k][c0+j], keeping the low DATA_W bits (wrap). Lanes with c0+j ≥ N are gated and unused.
  - WRITE (1 cycle): C[r][c0+j] <= acc_j for each lane with c0+j < N. Then advance the pass:
    - If c0+CORE_COUNT < N: c0 += CORE_COUNT.
    - Else: c0=0, r++.
    - If r was M-1 and this was the last column block: go to DONE; otherwise go to INIT.
  - DONE (1 cycle): busy=0, done=1, o_done_irq=1, go to IDLE.
- Passes: P = M * ceil(N/CORE_COUNT).
- CYCLES: increments on every INIT, MAC and WRITE cycle, so the final value is P*(K+2). It holds until the next valid start.
- Multiply is two's-complement, low DATA_W bits; this result is sign-independent.
- Reset values: FSM=IDLE; CTRL fields, busy, done, error, CYCLES, o_data_rdt and o_done_irq all 0. Matrix storage is not reset.
- Reset mid-operation aborts immediately. C keeps whatever passes were already written; no done or irq is produced.
- A STATUS write in the same cycle the FSM enters DONE: the done set wins.

Test Plan:
1. Identity multiply, M=K=N=4, CORE_COUNT=4: A=I, B[i][j]=10*i+j, start. Required: C==B; done=1; CYCLES=4*(4+2)=24; exactly one o_done_irq pulse.
2. Partial lanes, M=2, K=3, N=5: A all 1, B[k][j]=j+1. Required: C[r][j]=3*(j+1) for j<5; C columns 5..7 keep their preloaded 0xDEAD; CYCLES=4*5=20.
3. Accumulate mode: preload C all 7, A=I, B all 2, M=K=N=2, accum=1. Required: C all 9. Rerun the same start: C all 11.
4. Error and wrap:
   - K=0 start: error=1, busy never set, CYCLES unchanged.
   - K=9 start: error=1.
   - STATUS write: error clears.
   - A[0][0]=0xFFFFFFFF, B[0][0]=2, M=K=N=1: C[0][0]=0xFFFFFFFE.
5. Busy protection: during the run in scenario 1, write A[0][0]=99 and issue a new CTRL start. Required: both ignored and the result matches scenario 1. A STATUS read during the run shows busy=1.
6. Async reset mid-run: assert rst in the MAC phase of pass 2. Required: o_data_rdt, busy, done and CYCLES are 0 immediately. A subsequent valid start completes correctly.
